// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM encoding,
// parity mode constants and the parity check helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // data_xor is the XOR of all received data bits; par_bit the sampled parity bit
    function automatic logic parity_error(input logic data_xor, input logic par_bit,
                                          input int unsigned mode);
        logic w_x;
        w_x = data_xor ^ par_bit;
        case (mode)
            PARITY_ODD:  parity_error = ~w_x;
            PARITY_EVEN: parity_error = w_x;
            default:     parity_error = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through receive FIFO; a push while full is only accepted
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module uart_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_valid = (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, mid-bit sampling FSM with
// optional parity and 1/2 stop bits, feeding a FWFT FIFO of words plus flags.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1250,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned TMR_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF   = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL   = CLKS_PER_BIT - 1;
    localparam int unsigned FIFO_W = DATA_BITS + 2;

    if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic                 r_rx_meta;
    logic                 r_rx_s;
    rx_state_t            r_state;
    logic [TMR_W-1:0]     r_timer;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic [FIFO_W-1:0]    w_wdata;
    logic [FIFO_W-1:0]    w_rdata;
    logic                 w_valid;

    // Synchroniser idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_timer == '0);

    // The final stop sample pushes directly, so the frame error includes that sample
    assign w_push  = (r_state == ST_STOP) && w_tick &&
                     (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1));
    assign w_wdata = {r_perr, r_ferr | ~r_rx_s, r_shift};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= ST_START;
                        r_timer   <= TMR_W'(HALF);
                        r_bit_cnt <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_timer <= TMR_W'(FULL);
                        r_state <= r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_timer <= TMR_W'(FULL);
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_timer <= TMR_W'(FULL);
                        r_perr  <= parity_error(^r_shift, r_rx_s, PARITY);
                        r_state <= ST_STOP;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_timer <= TMR_W'(FULL);
                        if (!r_rx_s) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_rx_s ? ST_IDLE : ST_WAIT_HIGH;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_pop = w_valid && ready;

    uart_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_valid (w_valid),
        .o_drop  (w_drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
        end
    end

    assign data       = w_rdata[DATA_BITS-1:0];
    assign frame_err  = w_rdata[DATA_BITS];
    assign parity_err = w_rdata[DATA_BITS+1];
    assign valid      = w_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) driven
// with directed frames; a monitor compares every delivered word against a queue.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    typedef struct {
        int unsigned data;
        logic        pe;
        logic        fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;

    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic valid0, valid1, valid2;
    logic pe0, pe1, pe2, fe0, fe1, fe2, ovr0, ovr1, ovr2;

    exp_t q0[$], q1[$], q2[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_ovr = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ovr0));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ovr1));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .data(data2), .valid(valid2), .ready(ready2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ovr2));

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_word(input string name, input exp_t e, input int unsigned d,
                            input logic pe, input logic fe);
        n_vec++;
        if (d !== e.data || pe !== e.pe || fe !== e.fe) begin
            n_err++;
            $display("FAIL %s: got data=0x%0h pe=%b fe=%b, expected data=0x%0h pe=%b fe=%b",
                     name, d, pe, fe, e.data, e.pe, e.fe);
        end
    endtask

    task automatic unexpected(input string name, input int unsigned d);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected word 0x%0h, expected none", name, d);
    endtask

    // Consumer side: each negedge with valid && ready is exactly one pop
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ovr0) n_ovr++;
                if (valid0 && ready0) begin
                    if (q0.size() == 0) unexpected("dut0 word", 32'(data0));
                    else cmp_word("dut0 word", q0.pop_front(), 32'(data0), pe0, fe0);
                end
                if (valid1 && ready1) begin
                    if (q1.size() == 0) unexpected("dut1 word", 32'(data1));
                    else cmp_word("dut1 word", q1.pop_front(), 32'(data1), pe1, fe1);
                end
                if (valid2 && ready2) begin
                    if (q2.size() == 0) unexpected("dut2 word", 32'(data2));
                    else cmp_word("dut2 word", q2.pop_front(), 32'(data2), pe2, fe2);
                end
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int idx, input logic v);
        case (idx)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Sends bits[0] first, one bit time each
    task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(idx, bits[i]);
            cycles(CPB);
        end
        set_rx(idx, 1'b1);
    endtask

    task automatic send8n1(input logic [7:0] d, input bit expect_it);
        if (expect_it) q0.push_back('{32'(d), 1'b0, 1'b0});
        send_bits(0, {6'h3F, 1'b1, d, 1'b0}, 10);
        cycles(2 * CPB);
    endtask

    initial begin
        fork
            monitor();
        join_none

        cycles(5);
        rst = 1'b0;
        cycles(2);
        check("reset valid0", 32'(valid0), 0);
        check("reset data0", 32'(data0), 0);
        check("reset parity_err0", 32'(pe0), 0);
        check("reset frame_err0", 32'(fe0), 0);
        check("reset overrun0", 32'(ovr0), 0);
        check("reset valid1", 32'(valid1), 0);
        check("reset valid2", 32'(valid2), 0);

        // 8N1 basic word
        send8n1(8'hA5, 1'b1);

        // 8E1: 0x03 has even ones, parity bit 1 makes total odd -> error
        q1.push_back('{32'h03, 1'b1, 1'b0});
        send_bits(1, {5'h1F, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        cycles(2 * CPB);

        // 7O2: 0x5B has five ones, parity bit 0 keeps total odd
        q2.push_back('{32'h5B, 1'b0, 1'b0});
        send_bits(2, {4'hF, 2'b11, 1'b0, 7'h5B, 1'b0}, 11);
        cycles(2 * CPB);

        // Short low glitch on idle line is rejected
        rx0 = 1'b0;
        cycles(6);
        rx0 = 1'b1;
        cycles(3 * CPB);
        check("glitch state", 32'(dut0.r_state), 32'(ST_IDLE));
        check("glitch valid", 32'(valid0), 0);

        // Stop bit low, then line held low for 40 bit times
        q0.push_back('{32'h55, 1'b0, 1'b1});
        send_bits(0, {6'h00, 1'b0, 8'h55, 1'b0}, 10);
        rx0 = 1'b0;
        cycles(40 * CPB);
        check("break state", 32'(dut0.r_state), 32'(ST_WAIT_HIGH));
        rx0 = 1'b1;
        cycles(2 * CPB);
        send8n1(8'h3C, 1'b1);

        // Overrun: five words into a four-deep FIFO with no consumer
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send8n1(8'h11 + 8'(i), i < 4);
        end
        cycles(4);
        check("overrun count", 32'(n_ovr), 1);
        check("full valid", 32'(valid0), 1);
        ready0 = 1'b1;
        cycles(10);
        check("drained valid", 32'(valid0), 0);

        // Reset asserted during data bit 3 of 0x5A and held across the tail
        fork
            send_bits(0, {6'h3F, 1'b1, 8'h5A, 1'b0}, 10);
            begin
                cycles(4 * CPB + 8);
                rst = 1'b1;
            end
        join
        cycles(1);
        rst = 1'b0;
        cycles(2);
        check("midreset valid", 32'(valid0), 0);
        check("midreset state", 32'(dut0.r_state), 32'(ST_IDLE));
        send8n1(8'h3C, 1'b1);

        cycles(20 * CPB);
        check("dut0 missing words", 32'(q0.size()), 0);
        check("dut1 missing words", 32'(q1.size()), 0);
        check("dut2 missing words", 32'(q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
